// File: rtl/fastinput_pkg.sv
// fastinput_pkg: shared edge-mode encodings for the fast-input counter
package fastinput_pkg;
  localparam logic [1:0] EM_OFF  = 2'b00;
  localparam logic [1:0] EM_RISE = 2'b01;
  localparam logic [1:0] EM_FALL = 2'b10;
  localparam logic [1:0] EM_BOTH = 2'b11;
endpackage

// File: rtl/fastinput_chan.sv
// fastinput_chan: one input channel of synchroniser, glitch filter, edge qualifier and counter
module fastinput_chan
  import fastinput_pkg::*;
#(
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic [1:0]        mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              clr,
  output logic              edge_pulse,
  output logic [CW-1:0]     cnt,
  output logic              ovf
);
  logic [SYNC_STAGES-1:0] sy;
  logic [FILT_W:0] fc;
  logic s, f, f_prev, rise, fall;
  assign s = sy[SYNC_STAGES-1];
  assign rise = f & ~f_prev;
  assign fall = ~f & f_prev;
  assign edge_pulse = (rise & (mode == EM_RISE || mode == EM_BOTH)) |
                      (fall & (mode == EM_FALL || mode == EM_BOTH));
  // bring the raw pin into the clock domain
  always_ff @(posedge clk or negedge rst)
    if (!rst) sy <= '0;
    else sy <= {sy[SYNC_STAGES-2:0], din};
  // f follows s only after N+1 consecutive disagreeing cycles; a shortened N toggles at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      f  <= 1'b0;
      fc <= '0;
    end else if (filt_len == '0 || s == f) begin
      f  <= s;
      fc <= '0;
    end else if (fc >= {1'b0, filt_len}) begin
      f  <= ~f;
      fc <= '0;
    end else fc <= fc + 1'b1;
  // edge history and counting; a clear coincident with an edge keeps that edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      f_prev <= 1'b0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      f_prev <= f;
      if (clr) begin
        cnt <= CW'(edge_pulse);
        ovf <= 1'b0;
      end else if (edge_pulse) begin
        cnt <= cnt + 1'b1;
        ovf <= ovf | (&cnt);
      end
    end
endmodule

// File: rtl/fastinput_counter.sv
// fastinput_counter: multi-channel filtered edge counter with atomic snapshot
module fastinput_counter #(
  parameter int CH          = 4,
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     fast_in,
  input  logic [2*CH-1:0]   edge_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     clr,
  input  logic              snap,
  output logic [CH-1:0]     edge_pulse,
  output logic [CH*CW-1:0]  cnt_bus,
  output logic [CH*CW-1:0]  snap_bus,
  output logic              snap_valid,
  output logic [CH-1:0]     ovf
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    fastinput_chan #(.CW(CW), .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (fast_in[i]),
      .mode       (edge_mode[2*i +: 2]),
      .filt_len   (filt_len),
      .clr        (clr[i]),
      .edge_pulse (edge_pulse[i]),
      .cnt        (cnt_bus[i*CW +: CW]),
      .ovf        (ovf[i])
    );
  end
  // capture the pre-update counters of every channel in one edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      snap_bus   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) snap_bus <= cnt_bus;
    end
endmodule

// File: tb/tb_fastinput_counter.sv
// tb_fastinput_counter: directed scoreboard bench for 32-bit and 8-bit counter builds
module tb_fastinput_counter;
  import fastinput_pkg::*;
  logic clk = 1'b0, rst = 1'b1, snap = 1'b0;
  logic [3:0] fast_in = '0, filt_len = '0, clr = '0;
  logic [7:0] edge_mode = '0;
  logic [3:0] ep32, ep8, ovf32, ovf8;
  logic [127:0] cnt32, sb32;
  logic [31:0] cnt8, sb8;
  logic sv32, sv8;
  int vecs = 0, errs = 0;
  typedef struct {
    string        n;
    logic [127:0] b32;
    logic [31:0]  b8;
    logic [3:0]   o8;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fastinput_counter #(.CH(4), .CW(32)) u32 (
    .clk(clk), .rst(rst), .fast_in(fast_in), .edge_mode(edge_mode), .filt_len(filt_len),
    .clr(clr), .snap(snap), .edge_pulse(ep32), .cnt_bus(cnt32), .snap_bus(sb32),
    .snap_valid(sv32), .ovf(ovf32));
  fastinput_counter #(.CH(4), .CW(8)) u8 (
    .clk(clk), .rst(rst), .fast_in(fast_in), .edge_mode(edge_mode), .filt_len(filt_len),
    .clr(clr), .snap(snap), .edge_pulse(ep8), .cnt_bus(cnt8), .snap_bus(sb8),
    .snap_valid(sv8), .ovf(ovf8));

  task automatic check(string n, logic [127:0] act, logic [127:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, req);
    end
  endtask

  // monitor: every snapshot strobe must match the oldest expected entry
  always @(negedge clk)
    if (rst && (sv32 || sv8)) begin
      if (q.size() == 0) check("unexpected snap_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check({e.n, " snap_valid32"}, sv32, 1);
        check({e.n, " snap_valid8"}, sv8, 1);
        check({e.n, " snap_bus32"}, sb32, e.b32);
        check({e.n, " snap_bus8"}, sb8, e.b8);
        check({e.n, " ovf8"}, ovf8, e.o8);
        check({e.n, " ovf32"}, ovf32, 0);
      end
    end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int ch, int hi, int lo);
    fast_in[ch] = 1'b1;
    tick(hi);
    fast_in[ch] = 1'b0;
    tick(lo);
  endtask

  task automatic exp_snap(string n, logic [31:0] c0, logic [31:0] c1, logic [31:0] c2,
                          logic [31:0] c3, logic [3:0] o8);
    exp_t e;
    e.n   = n;
    e.b32 = {c3, c2, c1, c0};
    e.b8  = {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    e.o8  = o8;
    q.push_back(e);
  endtask

  task automatic do_snap(string n, logic [31:0] c0, logic [31:0] c1, logic [31:0] c2,
                         logic [31:0] c3, logic [3:0] o8);
    exp_snap(n, c0, c1, c2, c3, o8);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    tick(2);
  endtask

  task automatic clear_all();
    clr = '1;
    tick(1);
    clr = '0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset cnt32", cnt32, 0);
    check("reset ovf8", ovf8, 0);
    check("reset snap_valid", sv32, 0);
    check("reset edge_pulse", ep32, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    do_snap("reset snap", 0, 0, 0, 0, 0);
    // rising mode, N=0, first-increment latency
    edge_mode = {EM_RISE, EM_RISE, EM_RISE, EM_RISE};
    fast_in[0] = 1'b1;
    tick(3);
    check("latency cnt0 before", cnt32[31:0], 0);
    check("latency edge_pulse0", ep32[0], 1);
    tick(1);
    check("latency cnt0 after", cnt32[31:0], 1);
    fast_in[0] = 1'b0;
    tick(3);
    for (int i = 0; i < 9; i++) pulse(0, 2, 2);
    for (int i = 0; i < 3; i++) pulse(2, 2, 2);
    tick(8);
    do_snap("rise 10/0/3/0", 10, 0, 3, 0, 0);
    // edge modes on ch1
    clear_all();
    edge_mode = {EM_OFF, EM_OFF, EM_BOTH, EM_OFF};
    for (int i = 0; i < 5; i++) pulse(1, 2, 2);
    tick(8);
    do_snap("both ch1", 0, 10, 0, 0, 0);
    clear_all();
    edge_mode = {EM_OFF, EM_OFF, EM_FALL, EM_OFF};
    for (int i = 0; i < 5; i++) pulse(1, 2, 2);
    tick(8);
    do_snap("fall ch1", 0, 5, 0, 0, 0);
    clear_all();
    edge_mode = {EM_OFF, EM_OFF, EM_OFF, EM_OFF};
    for (int i = 0; i < 5; i++) pulse(1, 2, 2);
    tick(8);
    do_snap("off ch1", 0, 0, 0, 0, 0);
    // glitch filter N=3 on ch3
    clear_all();
    edge_mode = {EM_RISE, EM_OFF, EM_OFF, EM_OFF};
    filt_len = 4'd3;
    for (int i = 0; i < 3; i++) pulse(3, 3, 6);
    tick(8);
    do_snap("filter glitches", 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) pulse(3, 4, 6);
    fast_in[3] = 1'b1;
    tick(6);
    check("filter latency before", cnt32[127:96], 2);
    tick(1);
    check("filter latency after", cnt32[127:96], 3);
    fast_in[3] = 1'b0;
    tick(8);
    do_snap("filter pulses", 0, 0, 0, 3, 0);
    filt_len = 4'd0;
    // 8-bit wrap and overflow
    clear_all();
    edge_mode = {EM_OFF, EM_OFF, EM_OFF, EM_BOTH};
    for (int i = 0; i < 255; i++) begin
      fast_in[0] = ~fast_in[0];
      tick(1);
    end
    tick(8);
    do_snap("255 edges", 255, 0, 0, 0, 4'b0000);
    fast_in[0] = ~fast_in[0];
    tick(8);
    do_snap("256 edges wrap", 256, 0, 0, 0, 4'b0001);
    fast_in[0] = ~fast_in[0];
    tick(3);
    check("clr+edge edge_pulse0", ep8[0], 1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    tick(8);
    do_snap("clr with edge", 1, 0, 0, 0, 4'b0000);
    // atomic snapshot + clear
    fast_in = '0;
    edge_mode = {EM_RISE, EM_RISE, EM_RISE, EM_RISE};
    tick(8);
    clear_all();
    for (int i = 0; i < 7; i++) pulse(0, 2, 2);
    for (int i = 0; i < 4; i++) pulse(1, 2, 2);
    tick(8);
    fast_in[1] = 1'b1;
    tick(3);
    check("atomic edge_pulse1", ep32[1], 1);
    exp_snap("atomic snap+clr", 7, 4, 0, 0, 0);
    snap = 1'b1;
    clr = 4'b0001;
    tick(1);
    snap = 1'b0;
    clr = '0;
    fast_in[1] = 1'b0;
    tick(8);
    do_snap("after atomic", 0, 5, 0, 0, 0);
    // inputs high across reset release
    rst = 1'b0;
    fast_in = 4'hF;
    tick(2);
    check("reset2 cnt32", cnt32, 0);
    check("reset2 snap_bus32", sb32, 0);
    rst = 1'b1;
    tick(8);
    do_snap("high at release", 1, 1, 1, 1, 0);
    // asynchronous reset mid-count
    fast_in = '0;
    tick(2);
    fast_in = 4'hF;
    tick(2);
    #2 rst = 1'b0;
    #1;
    check("midrst cnt32", cnt32, 0);
    check("midrst cnt8", cnt8, 0);
    check("midrst snap_bus32", sb32, 0);
    check("midrst snap_bus8", sb8, 0);
    check("midrst edge_pulse", ep32, 0);
    check("midrst snap_valid", sv32, 0);
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fastinput_counter.md
# fastinput_counter

Parametrised multi-channel fast-input pulse counter: `CH` asynchronous digital inputs are synchronised, glitch-filtered and edge-qualified per channel, and each qualifying edge increments a `CW`-bit counter. It adds per-channel edge mode, clear, sticky overflow and an atomic all-channel snapshot to the fixed 4×32 rising-edge counter. It sits between the board input pins and the register/readout logic.

## Interface
- `CH`, 4: number of input channels (1..32)
- `CW`, 32: counter width per channel (8..32)
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2)
- `FILT_W`, 4: width of the glitch-filter length field
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `fast_in`  in  CH  raw asynchronous inputs
- `edge_mode`  in  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- `filt_len`  in  FILT_W  glitch-filter length N, shared by all channels; 0 = bypass
- `clr`  in  CH  per-channel synchronous clear pulse
- `snap`  in  1  snapshot request pulse
- `edge_pulse`  out  CH  one-cycle qualified-edge strobe per channel
- `cnt_bus`  out  CH*CW  live counters; channel i at [i*CW +: CW]
- `snap_bus`  out  CH*CW  snapshot counters, same packing
- `snap_valid`  out  1  one-cycle strobe: `snap_bus` updated
- `ovf`  out  CH  sticky per-channel overflow flag

## Operation
- Reset: sync chains, filtered level `f`, `f_prev`, filter counters, `cnt_bus`, `snap_bus`, `snap_valid`, `ovf`, `edge_pulse` all 0.
- Synchroniser: `SYNC_STAGES` flops; output `s`.
- Filter: if N=0, `f <= s` every cycle. If N>0, a per-channel stability counter counts consecutive cycles with `s != f`. It resets to 0 whenever `s == f`. `f` toggles on the cycle that count reaches N+1; the counter then returns to 0. Pulses of ≤N synchronised cycles never change `f`.
- Edge: `f_prev <= f`. `edge_pulse[i]` is combinational: rising = `f & ~f_prev`, falling = `~f & f_prev`, gated by `edge_mode`. Mode 00 gives no pulses.
- Counter: on `edge_pulse`, `cnt += 1`. Wrap 2^CW−1 → 0 sets `ovf[i]`; `ovf` stays set until `clr[i]`.
- Clear: `clr[i]` sets `cnt` to 0 and `ovf` to 0. If `clr[i]` and `edge_pulse[i]` occur in the same cycle, `cnt` becomes 1 and `ovf` becomes 0, so no edge is lost.
- Snapshot: `snap` captures every channel's pre-update `cnt_bus` value (the value visible in the request cycle) into `snap_bus` in the same cycle. `snap_valid` is high the following cycle for exactly one cycle.
  - `snap` together with `clr` yields an atomic read-and-clear.
  - Back-to-back `snap` requests each capture and each strobe.
- `edge_mode` and `filt_len` changes take effect on the next cycle. They do not reset `f` or the counters. A shortened `filt_len` below the current stability count toggles `f` on the next cycle.
- An input already high when `rst` deasserts produces one rising edge, because `f` resets to 0.

## Timing
- Input captured at clock edge k, N=0: `s` is valid after edge k+SYNC_STAGES−1. `f` updates at edge k+SYNC_STAGES. `edge_pulse` is high the cycle after that. `cnt` updates at edge k+SYNC_STAGES+1.
- With N>0, add N cycles to each of these.
- Minimum countable input period: 2·(N+1) clock cycles per full pulse.
- `snap` → `snap_bus` valid the next cycle, concurrently with `snap_valid`.
- Reset mid-operation: all state clears asynchronously, with no partial snapshot.

## Structure
- `fastinput_pkg`: edge-mode constants `EM_OFF`/`EM_RISE`/`EM_FALL`/`EM_BOTH`.
- Sub-module `fastinput_chan` holds one channel: synchroniser, filter, edge detect, counter, `ovf`. It is instantiated `CH` times by generate.
- The top level holds only snapshot capture and bus packing.

## Test plan
- CH=4, CW=32, N=0, mode 01: 10 pulses on `fast_in[0]`, 3 on `fast_in[2]` → `cnt` = 10, 0, 3, 0. The first increment occurs 3 clock edges after input capture.
- Mode 11 on ch1, 5 full pulses → `cnt1` = 10. Mode 10 → 5. Mode 00 → 0.
- N=3: 3-cycle glitches → no count. 4-cycle pulses → counted, with latency +3.
- CW=8: 255 edges → `cnt` = 255, `ovf` = 0. One more edge → `cnt` = 0, `ovf` = 1. `clr` coincident with an edge → `cnt` = 1, `ovf` = 0.
- `cnt0` = 7, `snap` + `clr[0]` in the same cycle, with an edge on ch1 at `cnt1` = 4 in that cycle → `snap_bus` = {…, 4, 7}, `snap_valid` is a 1-cycle strobe, then `cnt0` = 0 and `cnt1` = 5.
- `rst` low with `fast_in` = 4'hF, then released with mode 01 → each `cnt` = 1. `rst` asserted mid-count → all outputs 0 immediately.
